// File: rtl/digit_sequence_capture_pkg.sv
// Shared types and constants for the digit sequence capture block.
// Holds the FSM state encoding, the default sizing and the blank code.
package digit_sequence_capture_pkg;

    localparam int DEF_STABLE_CYCLES = 3;
    localparam int DEF_NUM_DIGITS    = 4;

    localparam logic [3:0] BLANK_CODE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2,
        FULL = 2'd3
    } state_t;

endpackage

// File: rtl/digit_sequence_capture_stabilizer.sv
// Debounce stage: tracks the candidate code and its run length, and
// strobes accept on the edge where the run reaches STABLE_CYCLES.
module digit_stabilizer
    import digit_sequence_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       arm,
    input  logic       qual,
    input  logic [3:0] digit_in,
    output logic [3:0] cand,
    output logic       accept
);

    localparam logic [3:0] LAST_RUN = 4'(STABLE_CYCLES - 1);

    logic [3:0] run;
    logic       match;
    logic       load;

    assign match  = qual && (digit_in == cand) && (digit_in != BLANK_CODE);
    assign accept = match && (run == LAST_RUN);

    // A new code restarts the run; blank or a completed accept zeroes it.
    assign load = (arm || (qual && !match)) && (digit_in != BLANK_CODE);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cand <= BLANK_CODE;
            run  <= 4'd0;
        end else if (load) begin
            cand <= digit_in;
            run  <= 4'd1;
        end else if (match && !accept) begin
            run <= run + 4'd1;
        end else begin
            run <= 4'd0;
        end
    end

endmodule

// File: rtl/digit_sequence_capture.sv
// Captures a sequence of debounced digit codes into a word and hands it
// to a consumer with a valid/ready handshake; flags digits lost while full.
module digit_sequence_capture
    import digit_sequence_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int NUM_DIGITS    = DEF_NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              digit_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] out_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              digit_count,
    output logic                    accept_pulse,
    output logic                    overflow
);

    localparam int         W        = 4 * NUM_DIGITS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    state_t         state;
    logic [W-1:0]   word;
    logic [2:0]     count;
    logic           pulse;
    logic           ovf;
    logic           prev_blank;
    logic [3:0]     cand;
    logic           accept;
    logic           blank;
    logic           ovf_set;
    logic [W+3:0]   shifted;

    digit_stabilizer #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stab (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .arm     (state == IDLE),
        .qual    (state == QUAL),
        .digit_in(digit_in),
        .cand    (cand),
        .accept  (accept)
    );

    assign blank   = (digit_in == BLANK_CODE);
    assign shifted = {word, cand};
    // Only a fresh blank-to-digit transition counts as a lost digit.
    assign ovf_set = (state == FULL) && prev_blank && !blank;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= IDLE;
            word       <= '0;
            count      <= 3'd0;
            pulse      <= 1'b0;
            ovf        <= 1'b0;
            prev_blank <= 1'b1;
        end else begin
            prev_blank <= blank;
            pulse      <= accept;
            if (ovf_set) ovf <= 1'b1;
            case (state)
                IDLE: if (!blank) state <= IDLE == IDLE ? QUAL : IDLE;
                QUAL: begin
                    if (accept) begin
                        word  <= shifted[W-1:0];
                        count <= count + 3'd1;
                        state <= (count == LAST_IDX) ? FULL : HOLD;
                    end else if (blank) begin
                        state <= IDLE;
                    end
                end
                HOLD: if (blank) state <= IDLE;
                FULL: begin
                    if (out_ready) begin
                        word  <= '0;
                        count <= 3'd0;
                        state <= blank ? IDLE : HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_word     = word;
    assign out_valid    = (state == FULL);
    assign digit_count  = count;
    assign accept_pulse = pulse;
    assign overflow     = ovf;

endmodule
